// File: rtl/seven_seg_pkg.sv
// rtl/seven_seg_pkg.sv - shared types, constants and sizing helper for the seven-segment scan controller
package seven_seg_pkg;

  // Two-phase scan: all anodes off (anti-ghosting gap), then one digit lit
  typedef enum logic {ST_BLANK, ST_SHOW} scan_state_t;

  localparam logic [6:0] SEG_BLANK   = 7'b1111111;
  localparam logic [3:0] DIGIT_BLANK = 4'hF;

  // Counter width able to hold 0..max(a,b)-1; never narrower than one bit
  function automatic int cnt_width(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return (m > 1) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/SevenSegmentDecoder.sv
// rtl/SevenSegmentDecoder.sv - active-low {g..a} decoder for digits 0-5, anything else blank
module SevenSegmentDecoder
  import seven_seg_pkg::*;
(
  input  logic [3:0] digit,
  output logic [6:0] seg
);

  // Common-anode patterns; unsupported values fall through to blank
  always_comb begin
    seg = SEG_BLANK;
    case (digit)
      4'd0:    seg = 7'b1000000;
      4'd1:    seg = 7'b1111001;
      4'd2:    seg = 7'b0100100;
      4'd3:    seg = 7'b0110000;
      4'd4:    seg = 7'b0011001;
      4'd5:    seg = 7'b0010010;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/seven_segment_scan_ctrl.sv
// rtl/seven_segment_scan_ctrl.sv - time-multiplexed anode scanner with frame-aligned double-buffered load
module seven_segment_scan_ctrl
  import seven_seg_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYCLES = 500
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load_valid,
  output logic                    load_ready,
  input  logic [4*NUM_DIGITS-1:0] load_digits,
  input  logic [NUM_DIGITS-1:0]   blank_mask,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [6:0]              seg
);

  localparam int CW = cnt_width(REFRESH_DIV, BLANK_CYCLES);
  localparam int IW = $clog2(NUM_DIGITS);

  localparam logic [CW-1:0]         BLANK_LAST = CW'(BLANK_CYCLES - 1);
  localparam logic [CW-1:0]         SHOW_LAST  = CW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0]         IDX_LAST   = IW'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] AN_OFF     = '1;
  localparam logic [NUM_DIGITS-1:0] AN_ONE     = NUM_DIGITS'(1);

  scan_state_t             state;
  logic [IW-1:0]           idx;
  logic [CW-1:0]           cnt;
  logic [4*NUM_DIGITS-1:0] active;
  logic [4*NUM_DIGITS-1:0] shadow;
  logic                    pending;

  logic                    commit;
  logic                    accept;
  logic [3:0]              dec_digit;
  logic [6:0]              dec_seg;

  // Frame boundary is the BLANK(0)->SHOW(0) edge; the new buffer goes live on that very edge
  assign commit = (state == ST_BLANK) && (cnt == BLANK_LAST) && (idx == '0) && pending;
  assign accept = load_valid && load_ready;

  // Decoder sees the digit about to be shown, taken from the shadow when this edge commits it
  assign dec_digit = commit ? shadow[{idx, 2'b00} +: 4] : active[{idx, 2'b00} +: 4];

  SevenSegmentDecoder u_decoder (
    .digit (dec_digit),
    .seg   (dec_seg)
  );

  // Scan FSM with registered anode/segment outputs and the load/commit handshake
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_BLANK;
      idx        <= '0;
      cnt        <= '0;
      an         <= AN_OFF;
      seg        <= SEG_BLANK;
      active     <= {NUM_DIGITS{DIGIT_BLANK}};
      shadow     <= {NUM_DIGITS{DIGIT_BLANK}};
      pending    <= 1'b0;
      load_ready <= 1'b1;
    end else begin
      case (state)
        ST_BLANK: begin
          if (cnt == BLANK_LAST) begin
            state <= ST_SHOW;
            cnt   <= '0;
            an    <= ~(AN_ONE << idx);
            // Mask is captured here and held for the whole visit
            seg   <= blank_mask[idx] ? SEG_BLANK : dec_seg;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        ST_SHOW: begin
          if (cnt == SHOW_LAST) begin
            state <= ST_BLANK;
            cnt   <= '0;
            idx   <= (idx == IDX_LAST) ? '0 : idx + IW'(1);
            an    <= AN_OFF;
            seg   <= SEG_BLANK;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: begin
          state <= ST_BLANK;
          cnt   <= '0;
        end
      endcase

      // ready is low whenever pending, so commit and accept never coincide
      if (commit) begin
        active     <= shadow;
        pending    <= 1'b0;
        load_ready <= 1'b1;
      end else if (accept) begin
        shadow     <= load_digits;
        pending    <= 1'b1;
        load_ready <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_seven_segment_scan_ctrl.sv
// tb/tb_seven_segment_scan_ctrl.sv - randomized self-checking bench against a frame-position reference model
module tb_seven_segment_scan_ctrl;

  localparam int ND    = 4;
  localparam int RD    = 8;
  localparam int BC    = 2;
  localparam int VISIT = RD + BC;
  localparam int FRAME = ND * VISIT;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          load_valid = 1'b0;
  logic          load_ready;
  logic [15:0]   load_digits = 16'h0;
  logic [3:0]    blank_mask = 4'h0;
  logic [3:0]    an;
  logic [6:0]    seg;

  int            compared = 0;
  int            mismatched = 0;

  // Reference model: position in the frame is derived from cycles elapsed since reset release
  int            e;
  logic [15:0]   m_act;
  logic [15:0]   m_shad;
  bit            m_pend;
  bit            m_xfer;
  logic [6:0]    m_seg;
  logic [3:0]    exp_an;
  logic [6:0]    exp_seg;
  bit            exp_ready;

  seven_segment_scan_ctrl #(
    .NUM_DIGITS   (ND),
    .REFRESH_DIV  (RD),
    .BLANK_CYCLES (BC)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .load_valid  (load_valid),
    .load_ready  (load_ready),
    .load_digits (load_digits),
    .blank_mask  (blank_mask),
    .an          (an),
    .seg         (seg)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] ref_dec(input logic [3:0] v);
    case (v)
      4'd0:    return 7'b1000000;
      4'd1:    return 7'b1111001;
      4'd2:    return 7'b0100100;
      4'd3:    return 7'b0110000;
      4'd4:    return 7'b0011001;
      4'd5:    return 7'b0010010;
      default: return 7'b1111111;
    endcase
  endfunction

  task automatic model_reset();
    e      = 0;
    m_act  = 16'hFFFF;
    m_shad = 16'hFFFF;
    m_pend = 1'b0;
    m_xfer = 1'b0;
    m_seg  = 7'h7F;
  endtask

  // Advance model and DUT by one clock; expectations describe the state after the edge
  task automatic cycle();
    int p, o, d;
    m_xfer = load_valid && !m_pend;
    e++;
    p = e % FRAME;
    o = p % VISIT;
    d = p / VISIT;
    if (p == BC && m_pend) begin
      m_act  = m_shad;
      m_pend = 1'b0;
    end
    if (m_xfer) begin
      m_shad = load_digits;
      m_pend = 1'b1;
    end
    if (o == BC) m_seg = blank_mask[d] ? 7'h7F : ref_dec(m_act[d*4 +: 4]);
    exp_an    = (o < BC) ? 4'hF : ~(4'b0001 << d);
    exp_seg   = (o < BC) ? 7'h7F : m_seg;
    exp_ready = !m_pend;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    load_valid = 1'b0;
    blank_mask = 4'h0;
    @(posedge clk);
    #1;
    if (an !== 4'hF) begin mismatched++; $display("FAIL reset_an got %b want 1111", an); end
    compared++;
    if (seg !== 7'h7F) begin mismatched++; $display("FAIL reset_seg got %b want 1111111", seg); end
    compared++;
    if (load_ready !== 1'b1) begin mismatched++; $display("FAIL reset_ready got %b want 1", load_ready); end
    compared++;
    rst = 1'b0;
    model_reset();
    for (int i = 0; i < FRAME + 10; i++) begin
      load_digits = 16'($urandom);
      cycle();
      if (an !== exp_an) begin mismatched++; $display("FAIL idle_an e=%0d got %b want %b", e, an, exp_an); end
      compared++;
      if (seg !== exp_seg) begin mismatched++; $display("FAIL idle_seg e=%0d got %b want %b", e, seg, exp_seg); end
      compared++;
    end
  endtask

  task automatic test_load();
    int n;
    n = $urandom_range(5, 25);
    for (int i = 0; i < n; i++) cycle();
    load_valid  = 1'b1;
    load_digits = 16'h5210;
    cycle();
    load_valid = 1'b0;
    for (int i = 0; i < 2 * FRAME + 5; i++) begin
      load_digits = 16'($urandom);
      if (load_ready !== exp_ready) begin mismatched++; $display("FAIL load_ready e=%0d got %b want %b", e, load_ready, exp_ready); end
      compared++;
      cycle();
      if (an !== exp_an) begin mismatched++; $display("FAIL load_an e=%0d got %b want %b", e, an, exp_an); end
      compared++;
      if (seg !== exp_seg) begin mismatched++; $display("FAIL load_seg e=%0d got %b want %b", e, seg, exp_seg); end
      compared++;
    end
  endtask

  task automatic test_back_to_back();
    int n;
    load_valid  = 1'b1;
    load_digits = {4'($urandom_range(0, 5)), 4'($urandom_range(0, 5)), 4'($urandom_range(0, 5)), 4'($urandom_range(0, 5))};
    cycle();
    load_digits = 16'h4321;
    n = 0;
    do begin
      cycle();
      if (load_ready !== exp_ready) begin mismatched++; $display("FAIL b2b_ready e=%0d got %b want %b", e, load_ready, exp_ready); end
      compared++;
      if (seg !== exp_seg) begin mismatched++; $display("FAIL b2b_hold_seg e=%0d got %b want %b", e, seg, exp_seg); end
      compared++;
      n++;
    end while (!m_xfer && n < 3 * FRAME);
    if (!m_xfer) begin mismatched++; $display("FAIL b2b_accept_timeout got %0d cycles want <%0d", n, 3 * FRAME); end
    compared++;
    load_valid = 1'b0;
    for (int i = 0; i < 2 * FRAME + 5; i++) begin
      load_digits = 16'($urandom);
      cycle();
      if (load_ready !== exp_ready) begin mismatched++; $display("FAIL b2b_ready2 e=%0d got %b want %b", e, load_ready, exp_ready); end
      compared++;
      if (an !== exp_an) begin mismatched++; $display("FAIL b2b_an e=%0d got %b want %b", e, an, exp_an); end
      compared++;
      if (seg !== exp_seg) begin mismatched++; $display("FAIL b2b_seg e=%0d got %b want %b", e, seg, exp_seg); end
      compared++;
    end
  endtask

  task automatic test_mask();
    blank_mask  = 4'b0100;
    load_valid  = 1'b1;
    load_digits = 16'h3333;
    cycle();
    load_valid = 1'b0;
    for (int i = 0; i < 2 * FRAME + 5; i++) begin
      cycle();
      if (seg !== exp_seg) begin mismatched++; $display("FAIL mask_seg e=%0d got %b want %b", e, seg, exp_seg); end
      compared++;
    end
    for (int i = 0; i < 3 * FRAME; i++) begin
      if ($urandom_range(0, 3) == 0) blank_mask = 4'($urandom);
      cycle();
      if (an !== exp_an) begin mismatched++; $display("FAIL mask_live_an e=%0d got %b want %b", e, an, exp_an); end
      compared++;
      if (seg !== exp_seg) begin mismatched++; $display("FAIL mask_live_seg e=%0d got %b want %b", e, seg, exp_seg); end
      compared++;
    end
    blank_mask = 4'h0;
  endtask

  task automatic test_invalid_digit();
    int gap;
    int k;
    logic [3:0] prev_an;
    load_digits = 16'($urandom);
    k = $urandom_range(0, 3);
    load_digits[k*4 +: 4] = 4'h9;
    load_valid = 1'b1;
    cycle();
    load_valid = 1'b0;
    gap = 0;
    prev_an = an;
    for (int i = 0; i < 3 * FRAME; i++) begin
      cycle();
      if (seg !== exp_seg) begin mismatched++; $display("FAIL inv_seg e=%0d got %b want %b", e, seg, exp_seg); end
      compared++;
      if ($countones(~an) > 1) begin mismatched++; $display("FAIL inv_onehot e=%0d got %b want at most one low", e, an); end
      compared++;
      if (an === 4'hF) begin
        gap++;
      end else begin
        if (prev_an === 4'hF) begin
          if (gap != BC) begin mismatched++; $display("FAIL inv_gap e=%0d got %0d want %0d", e, gap, BC); end
          compared++;
        end
        gap = 0;
      end
      prev_an = an;
    end
  endtask

  task automatic test_reset_mid();
    int n;
    n = 0;
    while (((e % FRAME) != 12 || m_pend) && n < 3 * FRAME) begin cycle(); n++; end
    load_valid  = 1'b1;
    load_digits = {4'($urandom_range(0, 5)), 4'($urandom_range(0, 5)), 4'($urandom_range(0, 5)), 4'($urandom_range(0, 5))};
    cycle();
    load_valid = 1'b0;
    n = 0;
    while ((e % FRAME) != 2 * VISIT + BC + 3 && n < 3 * FRAME) begin cycle(); n++; end
    if (!m_pend || an !== 4'b1011) begin mismatched++; $display("FAIL rstmid_setup got an=%b pend=%0d want an=1011 pend=1", an, m_pend); end
    compared++;
    #2;
    rst = 1'b1;
    #1;
    if (an !== 4'hF) begin mismatched++; $display("FAIL rstmid_an got %b want 1111", an); end
    compared++;
    if (seg !== 7'h7F) begin mismatched++; $display("FAIL rstmid_seg got %b want 1111111", seg); end
    compared++;
    if (load_ready !== 1'b1) begin mismatched++; $display("FAIL rstmid_ready got %b want 1", load_ready); end
    compared++;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    for (int i = 0; i < 2 * FRAME + 5; i++) begin
      cycle();
      if (an !== exp_an) begin mismatched++; $display("FAIL rstmid_after_an e=%0d got %b want %b", e, an, exp_an); end
      compared++;
      if (seg !== exp_seg) begin mismatched++; $display("FAIL rstmid_after_seg e=%0d got %b want %b", e, seg, exp_seg); end
      compared++;
      if (load_ready !== exp_ready) begin mismatched++; $display("FAIL rstmid_after_ready e=%0d got %b want %b", e, load_ready, exp_ready); end
      compared++;
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_load();
    test_back_to_back();
    test_mask();
    test_invalid_digit();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
